led_blink_sequencer: RTL

Command-driven controller for the board's two-LED blink datapath, running on the 12 MHz system clock. It accepts a blink command (mode plus repetition count) over a valid/ready handshake. It sequences the half-period timing and drives led1/led2 for the requested number of periods, then signals completion. Upstream logic (key handlers, status/alarm sources) uses it to schedule LED patterns instead of free-running a blink counter.

---
 rtl/led_blink_sequencer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/led_blink_sequencer.sv
// Command-driven two-LED blink sequencer: runs a latched mode for a number of
// full periods (or until abort), each period being two equal half-period phases.
module led_blink_sequencer #(
  parameter int unsigned HALF_PERIOD = 6_000_000,
  parameter int unsigned CNT_W       = 23,
  parameter int unsigned REP_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [REP_W-1:0] cmd_reps,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             led1,
  output logic             led2
);

  typedef enum logic [1:0] {StIdle, StPhA, StPhB} state_e;

  localparam logic [CNT_W-1:0] HalfLast = CNT_W'(HALF_PERIOD - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] half_cnt_q, half_cnt_d;
  logic [REP_W-1:0] period_cnt_q, period_cnt_d, period_inc;
  logic [REP_W-1:0] reps_q, reps_d;
  logic [1:0]       mode_q, mode_d;
  logic             busy_d, done_d, led1_d, led2_d;
  logic             accept, half_end;

  assign cmd_ready  = (state_q == StIdle) && !abort;
  assign accept     = cmd_valid && cmd_ready;
  assign half_end   = (half_cnt_q == HalfLast);
  assign period_inc = period_cnt_q + REP_W'(1);

  always_comb begin
    state_d      = state_q;
    half_cnt_d   = half_cnt_q;
    period_cnt_d = period_cnt_q;
    mode_d       = mode_q;
    reps_d       = reps_q;
    done_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d      = StPhA;
          half_cnt_d   = '0;
          period_cnt_d = '0;
          mode_d       = cmd_mode;
          reps_d       = cmd_reps;
        end
      end
      StPhA: begin
        if (abort) begin
          state_d = StIdle;
        end else if (half_end) begin
          state_d    = StPhB;
          half_cnt_d = '0;
        end else begin
          half_cnt_d = half_cnt_q + CNT_W'(1);
        end
      end
      StPhB: begin
        // Abort wins over natural completion, so no done pulse in that case.
        if (abort) begin
          state_d = StIdle;
        end else if (half_end) begin
          half_cnt_d = '0;
          if (reps_q != '0) period_cnt_d = period_inc;
          if ((reps_q != '0) && (period_inc == reps_q)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StPhA;
          end
        end else begin
          half_cnt_d = half_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // LEDs are registered from the next state so they change on the same edge as the phase.
  always_comb begin
    busy_d = (state_d != StIdle);
    led1_d = 1'b0;
    led2_d = 1'b0;
    if (state_d == StPhA) begin
      unique case (mode_d)
        2'd0:    begin led1_d = 1'b1; led2_d = 1'b1; end
        2'd1:    begin led1_d = 1'b1; led2_d = 1'b0; end
        2'd2:    begin led1_d = 1'b1; led2_d = 1'b1; end
        default: begin led1_d = 1'b1; led2_d = 1'b0; end
      endcase
    end else if (state_d == StPhB) begin
      unique case (mode_d)
        2'd0:    begin led1_d = 1'b0; led2_d = 1'b0; end
        2'd1:    begin led1_d = 1'b0; led2_d = 1'b1; end
        2'd2:    begin led1_d = 1'b1; led2_d = 1'b1; end
        default: begin led1_d = 1'b0; led2_d = 1'b0; end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      half_cnt_q   <= '0;
      period_cnt_q <= '0;
      mode_q       <= '0;
      reps_q       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      led1         <= 1'b0;
      led2         <= 1'b0;
    end else begin
      state_q      <= state_d;
      half_cnt_q   <= half_cnt_d;
      period_cnt_q <= period_cnt_d;
      mode_q       <= mode_d;
      reps_q       <= reps_d;
      busy         <= busy_d;
      done         <= done_d;
      led1         <= led1_d;
      led2         <= led2_d;
    end
  end

endmodule
